shmem_arbiter: RTL and testbench
================================

# shmem_arbiter

Round-robin arbiter that shares the single-port shared memory between `NUM_PROC` SIMD processors. Each processor raises a read or write request and holds it until granted. The arbiter issues at most one one-cycle grant per clock and steers the winner's address, write data and write size to the memory port. Read data is broadcast to all processors, and each starved requester is flagged.

## Interface
- `NUM_PROC`, 4: number of processor requesters (≥2).
- `MAX_WAIT`, 64: cycles a request may stay pending before its starve flag sets.
- `i_clk`  in  1: clock.
- `i_rstn`  in  1: asynchronous active-low reset.
- `i_req_rd`  in  NUM_PROC: per-processor read request.
- `i_req_wr`  in  NUM_PROC: per-processor write request.
- `i_addr`  in  NUM_PROC×addr_t: per-processor address, flattened; proc k at slice k.
- `i_wdata`  in  NUM_PROC×BUS_W: per-processor write data, flattened.
- `i_wr_size`  in  NUM_PROC×3: per-processor write element count.
- `o_grant_rd`  out  NUM_PROC: one-hot read grant.
- `o_grant_wr`  out  NUM_PROC: one-hot write grant.
- `o_rdata`  out  BUS_W: `i_mem_rdata`, broadcast to all processors.
- `o_mem_addr`  out  addr_t: winner's address.
- `o_mem_wdata`  out  BUS_W: winner's write data.
- `o_mem_wr_size`  out  3: winner's write size.
- `o_mem_rd_en`  out  1: memory read strobe.
- `o_mem_wr_en`  out  1: memory write strobe.
- `i_mem_rdata`  in  BUS_W: memory read data, combinational from `o_mem_addr`.
- `i_mem_ready`  in  1: memory can accept an access this cycle.
- `o_starve`  out  NUM_PROC: sticky starvation flags.

## Operation
- Request k is `i_req_rd[k] | i_req_wr[k]`. If both bits are set, the request is treated as a read. The write bit is ignored for that cycle.
- Winner: the first requesting index at or after `ptr`, searching upward and wrapping modulo `NUM_PROC`.
- `ptr` resets to 0. On a granted cycle it becomes `(winner+1) mod NUM_PROC`. It is otherwise unchanged.
- No grant is issued while `i_mem_ready=0`. Grants, `o_mem_rd_en` and `o_mem_wr_en` are all 0 that cycle and `ptr` holds.
- With no requests pending, all grants and strobes are 0.
  - `o_mem_addr`, `o_mem_wdata` and `o_mem_wr_size` show slice `ptr`.
  - Memory ignores these three while the strobes are 0.
- Per-requester wait counter (width clog2(MAX_WAIT)+1):
  - Clears when its requester is granted or not requesting.
  - Otherwise increments, saturating at MAX_WAIT.
  - When it reaches MAX_WAIT, `o_starve[k]` sets.
  - `o_starve[k]` clears only on reset.
- A request dropped without being granted is legal. Its counter clears and no grant is issued to it.

## Timing
- Zero-cycle grant latency: request, grant, memory strobe and read data all occur in the same cycle. The processor samples `o_rdata` on the edge that ends its grant cycle.
- Every grant lasts exactly one cycle, and each grant is one access. A requester holding its request is re-arbitrated on the next cycle behind the others.
- Worst-case wait with `i_mem_ready=1` throughout is NUM_PROC−1 cycles.
- Reset (async, mid-operation included):
  - `ptr`, counters and `o_starve` go to 0 immediately.
  - Grants and strobes go to 0 because they are gated by reset.
  - An in-flight access is abandoned; the requester still holds its request and is served after reset release.
- Requests, `i_mem_ready` and a `ptr` update all in one cycle: arbitration uses the pre-edge `ptr`.

## Structure
- Shared package (`defines.sv`): `addr_t`, `BUS_W`, `USIZE`, new `NUM_PROC` default.
- Sub-module `rr_picker`: parameter N.
  - Inputs: N-bit request vector, clog2(N) pointer.
  - Outputs: one-hot grant, binary winner index, valid.
  - Purely combinational.
- Top level holds `ptr`, the wait counters, the starve flags and the data-path multiplexers.

## Test plan
- Reset, no requests, NUM_PROC=4: all grants and strobes are 0, `o_starve=0`, `ptr=0`.
- `i_req_rd=4'b1111` held 8 cycles, ready=1: read grants go 0,1,2,3,0,1,2,3 in order. `o_mem_addr` tracks each winner's address.
- `i_req_wr[2]=1` with addr 0x40, data 0xA5.., size 3: same-cycle `o_grant_wr=4'b0100`, `o_mem_wr_en=1`, memory receives addr 0x40, data 0xA5.., size 3.
- `i_mem_ready=0` for 5 cycles with all requests high: no grants and `ptr` holds. On ready=1, the grant goes to the old `ptr` index.
- MAX_WAIT=4, `i_mem_ready=0` with `i_req_rd[1]=1`: `o_starve[1]` rises after 4 cycles and stays high after ready returns and the request is granted.
- Async reset asserted mid-grant while proc 3 is writing: `o_mem_wr_en` drops without a clock edge. After release, proc 3's held request is granted first (`ptr=0`, procs 0–2 idle).

Source files
------------

// File: rtl/shmem_arbiter_pkg.sv
// Shared types and widths for the shared-memory arbiter and the processors around it.
package shmem_arbiter_pkg;

  localparam int ADDR_W       = 16;
  localparam int BUS_W        = 64;
  localparam int USIZE        = 3;
  localparam int DEF_NUM_PROC = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  // Successor of idx in a ring of n slots.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int cand;

  // Scan from the farthest offset down so the nearest requester overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (req[cand]) begin
        valid       = 1'b1;
        idx         = PW'(cand);
        grant       = '0;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shmem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_PROC processors,
// with zero-latency one-cycle grants and sticky per-requester starvation flags.
module shmem_arbiter
  import shmem_arbiter_pkg::*;
#(
  parameter int NUM_PROC = DEF_NUM_PROC,
  parameter int MAX_WAIT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [NUM_PROC-1:0]       i_req_rd,
  input  logic [NUM_PROC-1:0]       i_req_wr,
  input  logic [NUM_PROC*ADDR_W-1:0] i_addr,
  input  logic [NUM_PROC*BUS_W-1:0] i_wdata,
  input  logic [NUM_PROC*USIZE-1:0] i_wr_size,
  output logic [NUM_PROC-1:0]       o_grant_rd,
  output logic [NUM_PROC-1:0]       o_grant_wr,
  output logic [BUS_W-1:0]          o_rdata,
  output addr_t                     o_mem_addr,
  output logic [BUS_W-1:0]          o_mem_wdata,
  output logic [USIZE-1:0]          o_mem_wr_size,
  output logic                      o_mem_rd_en,
  output logic                      o_mem_wr_en,
  input  logic [BUS_W-1:0]          i_mem_rdata,
  input  logic                      i_mem_ready,
  output logic [NUM_PROC-1:0]       o_starve
);

  localparam int PW    = $clog2(NUM_PROC);
  localparam int CNT_W = $clog2(MAX_WAIT) + 1;

  logic [PW-1:0]       ptr_reg;
  logic [NUM_PROC-1:0] req;
  logic [NUM_PROC-1:0] pick_grant;
  logic [NUM_PROC-1:0] grant;
  logic [PW-1:0]       pick_idx;
  logic [PW-1:0]       sel;
  logic                pick_valid;
  logic                grant_any;

  assign req = i_req_rd | i_req_wr;

  rr_picker #(.N(NUM_PROC)) u_picker (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Gating with i_rstn drops grants and strobes the instant reset asserts.
  assign grant_any = pick_valid & i_mem_ready & i_rstn;
  assign grant     = grant_any ? pick_grant : '0;

  // A simultaneous read and write request is served as a read.
  assign o_grant_rd  = grant & i_req_rd;
  assign o_grant_wr  = grant & i_req_wr & ~i_req_rd;
  assign o_mem_rd_en = |o_grant_rd;
  assign o_mem_wr_en = |o_grant_wr;

  // With nobody requesting the data path parks on the ptr slot.
  assign sel           = pick_valid ? pick_idx : ptr_reg;
  assign o_mem_addr    = i_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign o_mem_wdata   = i_wdata[int'(sel)*BUS_W +: BUS_W];
  assign o_mem_wr_size = i_wr_size[int'(sel)*USIZE +: USIZE];
  assign o_rdata       = i_mem_rdata;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= PW'(next_idx(int'(pick_idx), NUM_PROC));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROC; gi++) begin : g_wait
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             starve_reg;

      always_comb begin
        cnt_next = cnt_reg;
        if (!req[gi] || grant[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg != CNT_W'(MAX_WAIT)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          cnt_reg    <= '0;
          starve_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          starve_reg <= starve_reg | (cnt_next == CNT_W'(MAX_WAIT));
        end
      end

      assign o_starve[gi] = starve_reg;
    end
  endgenerate

endmodule

// File: tb/tb_shmem_arbiter.sv
// Directed bench for shmem_arbiter: round-robin order, writes, ready stalls, starvation, async reset.
module tb_shmem_arbiter;
  import shmem_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int MW = 4;

  logic                   clk;
  logic                   rstn;
  logic [NP-1:0]          req_rd;
  logic [NP-1:0]          req_wr;
  logic [NP*ADDR_W-1:0]   addr;
  logic [NP*BUS_W-1:0]    wdata;
  logic [NP*USIZE-1:0]    wr_size;
  logic [NP-1:0]          grant_rd;
  logic [NP-1:0]          grant_wr;
  logic [BUS_W-1:0]       rdata;
  addr_t                  mem_addr;
  logic [BUS_W-1:0]       mem_wdata;
  logic [USIZE-1:0]       mem_wr_size;
  logic                   mem_rd_en;
  logic                   mem_wr_en;
  logic [BUS_W-1:0]       mem_rdata;
  logic                   mem_ready;
  logic [NP-1:0]          starve;

  int checks = 0;
  int errors = 0;

  shmem_arbiter #(.NUM_PROC(NP), .MAX_WAIT(MW)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_req_rd      (req_rd),
    .i_req_wr      (req_wr),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .i_wr_size     (wr_size),
    .o_grant_rd    (grant_rd),
    .o_grant_wr    (grant_wr),
    .o_rdata       (rdata),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_wr_size (mem_wr_size),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_wr_en   (mem_wr_en),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ready   (mem_ready),
    .o_starve      (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] mem_model(input addr_t a);
    return {16'h5A5A, a, ~a, a};
  endfunction

  // Combinational memory: read data follows the address in the same cycle.
  assign mem_rdata = mem_model(mem_addr);

  function automatic addr_t slot_addr(input int k);
    return addr[k*ADDR_W +: ADDR_W];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    req_rd    = '0;
    req_wr    = '0;
    wdata     = '0;
    wr_size   = '0;
    mem_ready = 1'b1;
    for (int k = 0; k < NP; k++) addr[k*ADDR_W +: ADDR_W] = 16'(16'h1000 + k * 16);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant_rd", 64'(grant_rd), 64'h0);
    check("rst_grant_wr", 64'(grant_wr), 64'h0);
    check("rst_rd_en", 64'(mem_rd_en), 64'h0);
    check("rst_wr_en", 64'(mem_wr_en), 64'h0);
    check("rst_starve", 64'(starve), 64'h0);
    rstn = 1'b1;
    #1;
    check("idle_addr_ptr0", 64'(mem_addr), 64'(16'h1000));
    check("idle_rd_en", 64'(mem_rd_en), 64'h0);
    @(negedge clk);

    // All four reading: grants rotate 0,1,2,3,0,1,2,3
    req_rd = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #2;
      check("rr_grant_rd", 64'(grant_rd), 64'(4'b0001 << (i % 4)));
      check("rr_grant_wr", 64'(grant_wr), 64'h0);
      check("rr_rd_en", 64'(mem_rd_en), 64'h1);
      check("rr_addr", 64'(mem_addr), 64'(16'(16'h1000 + (i % 4) * 16)));
      check("rr_rdata", rdata, mem_model(16'(16'h1000 + (i % 4) * 16)));
      $display("txn rr %0d: grant_rd=%b addr=%h", i, grant_rd, mem_addr);
      @(negedge clk);
    end
    req_rd = '0;

    // Write from proc 2 (ptr is back at 0)
    addr[2*ADDR_W +: ADDR_W] = 16'h0040;
    wdata[2*BUS_W +: BUS_W]  = 64'hA5A5_A5A5_A5A5_A5A5;
    wr_size[2*USIZE +: USIZE] = 3'd3;
    req_wr = 4'b0100;
    #2;
    check("wr_grant_wr", 64'(grant_wr), 64'(4'b0100));
    check("wr_grant_rd", 64'(grant_rd), 64'h0);
    check("wr_en", 64'(mem_wr_en), 64'h1);
    check("wr_rd_en", 64'(mem_rd_en), 64'h0);
    check("wr_addr", 64'(mem_addr), 64'h40);
    check("wr_data", mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check("wr_size", 64'(mem_wr_size), 64'h3);
    $display("txn wr: grant_wr=%b addr=%h data=%h size=%0d", grant_wr, mem_addr, mem_wdata, mem_wr_size);
    @(negedge clk);
    req_wr = '0;

    // Proc 0 raises both read and write: treated as a read (ptr now 3)
    req_rd = 4'b0001;
    req_wr = 4'b0001;
    #2;
    check("both_grant_rd", 64'(grant_rd), 64'(4'b0001));
    check("both_grant_wr", 64'(grant_wr), 64'h0);
    check("both_wr_en", 64'(mem_wr_en), 64'h0);
    $display("txn both: grant_rd=%b grant_wr=%b", grant_rd, grant_wr);
    @(negedge clk);
    req_rd = '0;
    req_wr = '0;

    // Starvation of proc 1 while memory is busy (ptr now 1)
    mem_ready = 1'b0;
    req_rd    = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      #2;
      check("stv_no_grant", 64'(grant_rd), 64'h0);
      check("stv_rd_en", 64'(mem_rd_en), 64'h0);
      check("stv_pending", 64'(starve), 64'h0);
      @(negedge clk);
    end
    #2;
    check("stv_set", 64'(starve), 64'(4'b0010));
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    check("stv_grant", 64'(grant_rd), 64'(4'b0010));
    $display("txn starve: grant_rd=%b starve=%b", grant_rd, starve);
    @(negedge clk);
    req_rd = '0;
    #2;
    check("stv_sticky", 64'(starve), 64'(4'b0010));
    @(negedge clk);

    // All requesting, memory not ready for 5 cycles: ptr holds at 2
    mem_ready = 1'b0;
    req_rd    = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("hold_no_grant", 64'(grant_rd), 64'h0);
      check("hold_rd_en", 64'(mem_rd_en), 64'h0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #2;
    check("hold_grant_old_ptr", 64'(grant_rd), 64'(4'b0100));
    $display("txn hold: grant_rd=%b addr=%h", grant_rd, mem_addr);
    @(negedge clk);
    req_rd = '0;
    #2;
    check("hold_starve_all", 64'(starve), 64'(4'b1111));
    @(negedge clk);

    // Async reset in the middle of proc 3's write grant
    wdata[3*BUS_W +: BUS_W]   = 64'h0123_4567_89AB_CDEF;
    wr_size[3*USIZE +: USIZE] = 3'd5;
    req_wr = 4'b1000;
    #2;
    check("arst_pre_wr_en", 64'(mem_wr_en), 64'h1);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_wr_en_drop", 64'(mem_wr_en), 64'h0);
    check("arst_grant_drop", 64'(grant_wr), 64'h0);
    check("arst_starve_clr", 64'(starve), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    #2;
    check("arst_regrant", 64'(grant_wr), 64'(4'b1000));
    check("arst_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    check("arst_size", 64'(mem_wr_size), 64'h5);
    $display("txn arst: grant_wr=%b addr=%h", grant_wr, mem_addr);
    @(negedge clk);
    req_wr = '0;
    #2;
    check("arst_idle_ptr0", 64'(mem_addr), 64'(slot_addr(0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
